sw_wavefront_ctrl: RTL and testbench

Scheduler for the Smith-Waterman linear systolic PE array (NUM_PE lanes) that scores a query against a reference.
- Splits the query into Q_LEN/NUM_PE horizontal stripes and sweeps each stripe as a diagonal wavefront across the reference.
- Drives per-lane enables, column indices and boundary-buffer read/write strobes.
- Tracks the running maximum H score with its 1-based (ref, query) position; raises finish when the matrix is complete.

---
 rtl/sw_wavefront_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_sw_wavefront_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_wavefront_ctrl.sv
// Smith-Waterman wavefront scheduler: stripes the query over NUM_PE lanes and tracks the best H cell.
// Optional build macro SW_PERF_CNT_EN adds cycle_cnt / cell_cnt performance counters.
module sw_wavefront_ctrl #(
  parameter int NUM_PE          = 4,
  parameter int R_LEN           = 64,
  parameter int Q_LEN           = 48,
  parameter int WIDTH_SCORE     = 8,
  parameter int WIDTH_POS_REF   = 7,
  parameter int WIDTH_POS_QUERY = 6
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  output logic                               busy,
  output logic [NUM_PE-1:0]                  pe_en,
  output logic [NUM_PE*WIDTH_POS_REF-1:0]    pe_col,
  output logic [NUM_PE-1:0]                  pe_first_col,
  output logic [WIDTH_POS_QUERY-1:0]         stripe_base,
  output logic                               first_stripe,
  output logic                               bnd_rd_en,
  output logic [WIDTH_POS_REF-1:0]           bnd_rd_addr,
  output logic                               bnd_wr_en,
  output logic [WIDTH_POS_REF-1:0]           bnd_wr_addr,
  input  logic [NUM_PE*WIDTH_SCORE-1:0]      pe_h,
  output logic                               finish,
  output logic [WIDTH_SCORE-1:0]             max,
  output logic [WIDTH_POS_REF-1:0]           pos_ref,
  output logic [WIDTH_POS_QUERY-1:0]         pos_query
`ifdef SW_PERF_CNT_EN
  ,
  output logic [15:0]                        cycle_cnt,
  output logic [15:0]                        cell_cnt
`endif
);

  localparam int WR      = WIDTH_POS_REF;
  localparam int WQ      = WIDTH_POS_QUERY;
  localparam int WS      = WIDTH_SCORE;
  localparam int STRIPES = Q_LEN / NUM_PE;
  localparam int T_LAST  = R_LEN + NUM_PE - 2;
  localparam int TW      = $clog2(T_LAST + 2);
  localparam int SW      = $clog2(STRIPES + 1);

  // state | meaning
  // IDLE  | waiting for start; result registers hold
  // RUN   | sweeping wavefronts stripe by stripe
  // FLUSH | last lane results arrive from the PEs
  // DONE  | finish pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t             state, state_nxt;
  logic [TW-1:0]      t_cnt, t_nxt;
  logic [SW-1:0]      s_cnt, s_nxt;
  logic               last_cycle;
  logic [NUM_PE-1:0]  en_nxt, first_nxt;
  logic [NUM_PE*WR-1:0] col_nxt;
  logic [NUM_PE-1:0]  h_valid;
  logic [NUM_PE*WR-1:0] col_d;
  logic [WQ-1:0]      base_d;
  logic               cand_found;
  logic [WS-1:0]      cand_h;
  logic [WR-1:0]      cand_ref;
  logic [WQ-1:0]      cand_query;

  assign last_cycle = (t_cnt == TW'(T_LAST)) && (s_cnt == SW'(STRIPES - 1));
  assign busy       = (state != IDLE);
  assign finish     = (state == DONE);
  assign bnd_wr_en  = h_valid[NUM_PE-1];
  assign bnd_wr_addr = col_d[(NUM_PE-1)*WR +: WR];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = '0;
    s_nxt     = '0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        if (last_cycle) begin
          state_nxt = FLUSH;
        end else if (t_cnt == TW'(T_LAST)) begin
          s_nxt = s_cnt + SW'(1);
        end else begin
          t_nxt = t_cnt + TW'(1);
          s_nxt = s_cnt;
        end
      end
      FLUSH: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane outputs are computed from the next wavefront index so they are registered in step with it.
  always_comb begin
    en_nxt    = '0;
    first_nxt = '0;
    col_nxt   = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (state_nxt == RUN && int'(t_nxt) >= k && int'(t_nxt) < k + R_LEN) begin
        en_nxt[k]             = 1'b1;
        col_nxt[k*WR +: WR]   = WR'(int'(t_nxt) - k);
        first_nxt[k]          = (int'(t_nxt) == k);
      end
    end
  end

  // Lowest lane wins ties because later lanes must be strictly greater to replace it.
  always_comb begin
    cand_found = 1'b0;
    cand_h     = '0;
    cand_ref   = '0;
    cand_query = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (h_valid[k] && (!cand_found || pe_h[k*WS +: WS] > cand_h)) begin
        cand_found = 1'b1;
        cand_h     = pe_h[k*WS +: WS];
        cand_ref   = col_d[k*WR +: WR] + WR'(1);
        cand_query = base_d + WQ'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_cnt        <= '0;
      s_cnt        <= '0;
      pe_en        <= '0;
      pe_col       <= '0;
      pe_first_col <= '0;
      stripe_base  <= '0;
      first_stripe <= 1'b0;
      bnd_rd_en    <= 1'b0;
      bnd_rd_addr  <= '0;
      h_valid      <= '0;
      col_d        <= '0;
      base_d       <= '0;
      max          <= '0;
      pos_ref      <= '0;
      pos_query    <= '0;
    end else begin
      t_cnt        <= t_nxt;
      s_cnt        <= s_nxt;
      pe_en        <= en_nxt;
      pe_col       <= col_nxt;
      pe_first_col <= first_nxt;
      stripe_base  <= (state_nxt == RUN) ? WQ'(int'(s_nxt) * NUM_PE) : '0;
      first_stripe <= (state_nxt == RUN) && (s_nxt == '0);
      bnd_rd_en    <= en_nxt[0] && (s_nxt != '0);
      bnd_rd_addr  <= col_nxt[WR-1:0];
      h_valid      <= pe_en;
      col_d        <= pe_col;
      base_d       <= stripe_base;
      if (state == IDLE && start) begin
        max       <= '0;
        pos_ref   <= '0;
        pos_query <= '0;
      end else if ((state == RUN || state == FLUSH) && cand_found && cand_h > max) begin
        max       <= cand_h;
        pos_ref   <= cand_ref;
        pos_query <= cand_query;
      end
    end
  end

`ifdef SW_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      cell_cnt  <= '0;
    end else if (state == IDLE && start) begin
      cycle_cnt <= '0;
      cell_cnt  <= '0;
    end else if (busy) begin
      if (cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'd1;
      cell_cnt <= cell_cnt + 16'($countones(pe_en));
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_sw_wavefront_ctrl.sv
// Self-checking bench for sw_wavefront_ctrl: per-cycle lane schedule plus a matrix-level max/position model.
module tb_sw_wavefront_ctrl;
  localparam int NP = 4, RL = 64, QL = 48, WS = 8, WR = 7, WQ = 6;
  localparam int ST = QL / NP;
  localparam int TL = RL + NP - 1;
  localparam int RUNC = ST * TL;
  localparam int FIN_C = RUNC + 2;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic busy, first_stripe, bnd_rd_en, bnd_wr_en, finish;
  logic [NP-1:0] pe_en, pe_first_col;
  logic [NP*WR-1:0] pe_col;
  logic [WQ-1:0] stripe_base, pos_query;
  logic [WR-1:0] bnd_rd_addr, bnd_wr_addr, pos_ref;
  logic [NP*WS-1:0] pe_h = '0;
  logic [WS-1:0] max;
`ifdef SW_PERF_CNT_EN
  logic [15:0] cycle_cnt, cell_cnt;
`endif

  int hm [QL][RL];
  int errors = 0;
  int checks = 0;

  sw_wavefront_ctrl #(.NUM_PE(NP), .R_LEN(RL), .Q_LEN(QL), .WIDTH_SCORE(WS),
                      .WIDTH_POS_REF(WR), .WIDTH_POS_QUERY(WQ)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .pe_en(pe_en), .pe_col(pe_col),
    .pe_first_col(pe_first_col), .stripe_base(stripe_base), .first_stripe(first_stripe),
    .bnd_rd_en(bnd_rd_en), .bnd_rd_addr(bnd_rd_addr), .bnd_wr_en(bnd_wr_en),
    .bnd_wr_addr(bnd_wr_addr), .pe_h(pe_h), .finish(finish), .max(max),
    .pos_ref(pos_ref), .pos_query(pos_query)
`ifdef SW_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .cell_cnt(cell_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Best cell in processing order: stripe, then anti-diagonal time, then lane; strict improvement only.
  task automatic compute_expected(output int mx, output int pr, output int pq);
    mx = 0; pr = 0; pq = 0;
    for (int s = 0; s < ST; s++)
      for (int t = 0; t < TL; t++)
        for (int k = 0; k < NP; k++)
          if (t - k >= 0 && t - k < RL && hm[s*NP+k][t-k] > mx) begin
            mx = hm[s*NP+k][t-k];
            pr = t - k + 1;
            pq = s * NP + k + 1;
          end
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < QL; r++)
      for (int c = 0; c < RL; c++)
        hm[r][c] = (kind == 1) ? int'($urandom_range(0, 255)) : 0;
  endtask

  task automatic run_frame(input bit rand_garbage, input int restart_c, input int abort_c);
    int c, n, s, t, v, mx, pr, pq, wr_count;
    logic [NP-1:0] e_en, e_fc;
    logic [NP*WR-1:0] e_col;
    logic [WQ-1:0] e_base;
    logic [WR-1:0] e_rda, e_wra;
    logic e_fs, e_rd, e_wr;
    compute_expected(mx, pr, pq);
    wr_count = 0;
    @(negedge clk);
    start = 1'b1;
    c = 0;
    while (c < FIN_C + 2) begin
      @(negedge clk);
      c++;
      start = (c == restart_c);
      e_en = '0; e_fc = '0; e_col = '0; e_base = '0; e_fs = 1'b0; e_rd = 1'b0;
      e_rda = '0; e_wr = 1'b0; e_wra = '0;
      if (c >= 1 && c <= RUNC) begin
        n = c - 1; s = n / TL; t = n % TL;
        e_base = WQ'(s * NP);
        e_fs = (s == 0);
        for (int k = 0; k < NP; k++)
          if (t >= k && t < k + RL) begin
            e_en[k] = 1'b1;
            e_col[k*WR +: WR] = WR'(t - k);
            e_fc[k] = (t == k);
          end
        e_rd = e_en[0] && !e_fs;
        e_rda = e_col[WR-1:0];
      end
      if (c >= 2 && c <= RUNC + 1) begin
        t = (c - 2) % TL;
        if (t >= NP - 1 && t < NP - 1 + RL) begin
          e_wr = 1'b1;
          e_wra = WR'(t - (NP - 1));
        end
      end
      checks++;
      if (pe_en !== e_en) begin errors++; $display("FAIL pe_en c=%0d got %b want %b", c, pe_en, e_en); end
      checks++;
      if (pe_col !== e_col) begin errors++; $display("FAIL pe_col c=%0d got %h want %h", c, pe_col, e_col); end
      checks++;
      if (pe_first_col !== e_fc) begin errors++; $display("FAIL pe_first_col c=%0d got %b want %b", c, pe_first_col, e_fc); end
      checks++;
      if ({stripe_base, first_stripe} !== {e_base, e_fs}) begin
        errors++; $display("FAIL stripe c=%0d got base=%0d first=%b want base=%0d first=%b", c, stripe_base, first_stripe, e_base, e_fs);
      end
      checks++;
      if ({bnd_rd_en, bnd_rd_addr} !== {e_rd, e_rda}) begin
        errors++; $display("FAIL bnd_rd c=%0d got %b/%0d want %b/%0d", c, bnd_rd_en, bnd_rd_addr, e_rd, e_rda);
      end
      checks++;
      if ({bnd_wr_en, bnd_wr_addr} !== {e_wr, e_wra}) begin
        errors++; $display("FAIL bnd_wr c=%0d got %b/%0d want %b/%0d", c, bnd_wr_en, bnd_wr_addr, e_wr, e_wra);
      end
      checks++;
      if ({busy, finish} !== {(c <= FIN_C), (c == FIN_C)}) begin
        errors++; $display("FAIL busy_finish c=%0d got %b%b want %b%b", c, busy, finish, (c <= FIN_C), (c == FIN_C));
      end
      if (bnd_wr_en === 1'b1) wr_count++;
      if (c == 1) begin
        checks++;
        if ({max, pos_ref, pos_query} !== '0) begin
          errors++; $display("FAIL start_clear got max=%0d ref=%0d q=%0d want 0", max, pos_ref, pos_query);
        end
      end
      if (c == abort_c) begin
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, pe_en, pe_col, pe_first_col, stripe_base, first_stripe, bnd_rd_en, bnd_rd_addr,
             bnd_wr_en, bnd_wr_addr, finish, max, pos_ref, pos_query} !== '0) begin
          errors++; $display("FAIL abort_zero outputs not cleared by reset");
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          checks++;
          if ({busy, finish, pe_en} !== '0) begin
            errors++; $display("FAIL abort_idle i=%0d got busy=%b finish=%b pe_en=%b want 0", i, busy, finish, pe_en);
          end
        end
        return;
      end
      for (int k = 0; k < NP; k++) begin
        v = rand_garbage ? int'($urandom_range(0, 255)) : 0;
        n = c - 2;
        if (n >= 0 && n < RUNC) begin
          s = n / TL; t = n % TL;
          if (t >= k && t < k + RL) v = hm[s*NP+k][t-k];
        end
        pe_h[k*WS +: WS] = WS'(v);
      end
      if (c == FIN_C || c == FIN_C + 2) begin
        checks++;
        if (max !== WS'(mx) || pos_ref !== WR'(pr) || pos_query !== WQ'(pq)) begin
          errors++; $display("FAIL result c=%0d got max=%0d ref=%0d q=%0d want max=%0d ref=%0d q=%0d", c, max, pos_ref, pos_query, mx, pr, pq);
        end
      end
      if (c == FIN_C + 1) begin
        checks++;
        if (wr_count != RL * ST) begin
          errors++; $display("FAIL bnd_wr_count got %0d want %0d", wr_count, RL * ST);
        end
`ifdef SW_PERF_CNT_EN
        checks++;
        if (cycle_cnt !== 16'(FIN_C) || cell_cnt !== 16'(RL * QL)) begin
          errors++; $display("FAIL perf got cyc=%0d cell=%0d want cyc=%0d cell=%0d", cycle_cnt, cell_cnt, FIN_C, RL * QL);
        end
`endif
      end
    end
    start = 1'b0;
    pe_h = '0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, pe_en, pe_col, pe_first_col, stripe_base, first_stripe, bnd_rd_en, bnd_rd_addr,
         bnd_wr_en, bnd_wr_addr, finish, max, pos_ref, pos_query} !== '0) begin
      errors++; $display("FAIL reset_zero outputs not zero under reset");
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, finish, pe_en, bnd_wr_en, bnd_rd_en, max} !== '0) begin
        errors++; $display("FAIL reset_idle i=%0d got busy=%b finish=%b pe_en=%b max=%0d want 0", i, busy, finish, pe_en, max);
      end
    end
  endtask

  task automatic test_single_zero();
    fill(0);
    run_frame(1'b0, 0, 0);
  endtask

  task automatic test_single_cell();
    fill(0);
    hm[6][9] = 9;
    run_frame(1'b0, 0, 0);
    checks++;
    if (max !== 8'd9 || pos_query !== 6'd7 || pos_ref !== 7'd10) begin
      errors++; $display("FAIL single_cell got max=%0d q=%0d ref=%0d want 9/7/10", max, pos_query, pos_ref);
    end
  endtask

  task automatic test_tie();
    fill(0);
    hm[1][20] = 5;
    hm[3][18] = 5;
    hm[9][40] = 5;
    run_frame(1'b1, 0, 0);
    checks++;
    if (max !== 8'd5 || pos_query !== 6'd2 || pos_ref !== 7'd21) begin
      errors++; $display("FAIL tie got max=%0d q=%0d ref=%0d want 5/2/21", max, pos_query, pos_ref);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2; i++) begin
      fill(1);
      run_frame(1'b1, 0, 0);
    end
  endtask

  task automatic test_abort();
    fill(1);
    run_frame(1'b1, 3, 1 + 5 * TL + 10);
    fill(1);
    run_frame(1'b1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single_zero();
    test_single_cell();
    test_tie();
    test_random();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
